usart_rx_frame: RTL and testbench
=================================

// Module: usart_rx_frame
// PURPOSE
// - Asynchronous serial receiver (8N1 by default) for the USART datapath.
// - Oversamples rxd, deserialises one frame LSB-first and checks the stop bit.
// - Presents the received word plus an address-match flag to the downstream
//   equality-compare and address-filter stage.
// - Upstream is the rxd pad; downstream consumes rx_data, rx_valid and addr_match.
// PARAMETERS
// - DATA_W   8   data bits per frame (range 5..9).
// - OVS      16  oversample ticks per bit (even, >= 8).
// - CLK_DIV  4   clk cycles per oversample tick (>= 1); bit time = OVS*CLK_DIV clk.
// PORTS
// - clk         in   1       single system clock; all logic is on its rising edge.
// - rst         in   1       synchronous, active-high reset.
// - rxd         in   1       asynchronous serial input; idles high.
// - own_addr    in   DATA_W  station address that rx_data is compared against.
// - rx_data     out  DATA_W  last received word; holds until the next valid frame.
// - rx_valid    out  1       1-clk pulse: a good frame is available in rx_data.
// - addr_match  out  1       1-clk pulse with rx_valid when rx_data == own_addr.
// - frame_err   out  1       1-clk pulse: stop bit sampled 0; rx_valid stays 0.
// - busy        out  1       high from the accepted start edge until return to IDLE.
// BEHAVIOUR
// - Reset: state IDLE.
//   - rx_data = 0; rx_valid, addr_match, frame_err and busy = 0.
//   - Synchroniser flops = 1; divider and counters = 0.
// - rxd passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s.
// - The tick divider counts 0..CLK_DIV-1 and emits tick on the terminal count.
//   It is held at 0 while in IDLE, so the phase aligns to the start edge.
// - FSM states: IDLE, START, DATA, STOP. Transitions happen only on tick, except
//   IDLE->START, which happens on the clk where rxd_s == 0.
//   - IDLE:  rxd_s == 0 -> START, tick_cnt = 0, busy = 1.
//   - START: at tick_cnt == OVS/2-1, sample rxd_s.
//     - 0 -> DATA, tick_cnt = 0, bit_cnt = 0.
//     - 1 -> IDLE (glitch rejected, no output pulse).
//   - DATA:  at each tick_cnt == OVS-1, shift rxd_s into shreg MSB and shift right
//     (LSB-first). tick_cnt wraps to 0.
//     - Stay in DATA while bit_cnt != DATA_W-1, then bit_cnt++.
//     - Go to STOP after the DATA_W-th bit.
//   - STOP:  at tick_cnt == OVS-1, sample rxd_s, then -> IDLE.
//     - 1: rx_data <= shreg; rx_valid <= 1; addr_match <= (shreg == own_addr).
//     - 0: frame_err <= 1; rx_data is unchanged.
// - Output timing: rx_valid, addr_match and frame_err are registered and high for
//   exactly 1 clk, on the clk after the stop-bit sample.
//   - Latency from the start-edge detect: about (DATA_W+1.5)*OVS*CLK_DIV + 1 clk.
// - own_addr is sampled only at the stop-bit sample; it may change at any other time.
// - Back-to-back frames: a start edge on the clk right after the return to IDLE
//   must be accepted. There is no dead time beyond the synchroniser delay.
// - rxd stuck low after frame_err: IDLE re-enters START at once. Each bit time of a
//   break gives another frame_err. No lock-up.
// - busy falls on the same clk as the rx_valid or frame_err pulse.
// - rst asserted mid-frame: on the next clk, return to the full reset state. The
//   partial frame is discarded with no pulse.
// STRUCTURE
// - Shared package/header (usart_pkg) holds:
//   - RX state encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
//   - Default DATA_W, OVS and CLK_DIV constants used by the TX side.
// - One sub-module: usart_tick_gen (CLK_DIV divider with a synchronous clear input).
// - The shreg == own_addr compare is inline: a DATA_W-wide XNOR-AND reduction.
// TESTING (defaults DATA_W=8, OVS=16, CLK_DIV=4, so 64 clk per bit)
// - Frame 0xA5, own_addr=0xA5.
//   -> one rx_valid pulse, rx_data=0xA5, addr_match=1, frame_err=0.
//   -> the pulse lands 608+/-4 clk after the start edge.
// - Frame 0x3C, own_addr=0xA5.
//   -> rx_valid=1, rx_data=0x3C, addr_match=0.
// - Frame 0x55 with stop bit driven 0.
//   -> frame_err 1-clk pulse, rx_valid=0, rx_data keeps the prior value.
// - Low glitch of 20 clk on idle rxd.
//   -> busy goes high then low, no rx_valid or frame_err pulse.
//   -> the following frame 0x81 is received correctly.
// - rst for 1 clk at the 4th data bit of frame 0xF0.
//   -> all outputs 0 and busy=0 the next clk, no pulse.
//   -> the next frame 0x0F gives rx_data=0x0F.
// - Back-to-back frames 0x00, 0xFF, 0x5A with no idle gap.
//   -> three rx_valid pulses with the data in order, no frame_err.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared USART constants: RX FSM state encodings and default frame geometry.
package usart_pkg;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam int unsigned USART_DATA_W  = 8;
  localparam int unsigned USART_OVS     = 16;
  localparam int unsigned USART_CLK_DIV = 4;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usart_tick_gen.sv
// Oversample tick divider: counts 0..CLK_DIV-1, pulses tick on the terminal count.
module usart_tick_gen import usart_pkg::*; #(
  parameter int unsigned CLK_DIV = USART_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned    CW       = cnt_width(CLK_DIV);
  localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q;

  // Clear suppresses tick so the first tick after release lands a full period later.
  assign tick = !clear && (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/usart_rx_frame.sv
// Oversampling asynchronous serial receiver: deserialises one LSB-first frame,
// checks the stop bit and flags a match against the station address.
module usart_rx_frame import usart_pkg::*; #(
  parameter int unsigned DATA_W  = USART_DATA_W,
  parameter int unsigned OVS     = USART_OVS,
  parameter int unsigned CLK_DIV = USART_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic [DATA_W-1:0] own_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              addr_match,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned    TCW      = cnt_width(OVS);
  localparam int unsigned    BCW      = cnt_width(DATA_W);
  localparam logic [TCW-1:0] TICK_MID = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0] TICK_END = TCW'(OVS - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

  logic              rxd_meta_q;
  logic              rxd_s;
  logic              tick;

  logic [1:0]        state_q,      state_d;
  logic [TCW-1:0]    tick_cnt_q,   tick_cnt_d;
  logic [BCW-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [DATA_W-1:0] shreg_q,      shreg_d;
  logic [DATA_W-1:0] rx_data_q,    rx_data_d;
  logic              rx_valid_q,   rx_valid_d;
  logic              addr_match_q, addr_match_d;
  logic              frame_err_q,  frame_err_d;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s      <= rxd_meta_q;
    end
  end

  usart_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == RX_IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    addr_match_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      RX_START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A start bit that is high again at mid-bit was a glitch.
            state_d    = rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            shreg_d    = {rxd_s, shreg_q[DATA_W-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_d = RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            state_d    = RX_IDLE;
            if (rxd_s) begin
              rx_data_d    = shreg_q;
              rx_valid_d   = 1'b1;
              addr_match_d = &(shreg_q ~^ own_addr);
            end else begin
              frame_err_d  = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_usart_rx_frame.sv
// Directed bench for usart_rx_frame at default geometry (64 clk per bit).
module tb_usart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] own_addr = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       frame_err;
  logic       busy;

  usart_rx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .own_addr   (own_addr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .addr_match (addr_match),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse capture, sampled away from the active edge.
  int         n_valid = 0;
  int         n_err = 0;
  int         n_long = 0;
  int         valid_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_match = 1'b0;
  logic       saw_busy = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] data_q[$];
  logic       match_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      valid_cyc  = cyc;
      last_data  = rx_data;
      last_match = addr_match;
      data_q.push_back(rx_data);
      match_q.push_back(addr_match);
    end
    if (frame_err) n_err++;
    if ((rx_valid && prev_valid) || (frame_err && prev_err)) n_long++;
    if (busy) saw_busy = 1'b1;
    prev_valid = rx_valid;
    prev_err   = frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    start_cyc = cyc;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(64);
    end
    rxd = stop;
    wait_clk(64);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    wait_clk(3);
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    vectors++;
    if ({rx_valid, addr_match, frame_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b want 000", {rx_valid, addr_match, frame_err});
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_match;
    int nv, ne, lat;
    nv = n_valid;
    ne = n_err;
    own_addr = 8'hA5;
    send_frame(8'hA5, 1'b1);
    wait_clk(20);
    lat = valid_cyc - start_cyc;
    vectors++;
    if (n_valid !== nv + 1) begin
      miscompares++;
      $display("FAIL match_count: got %0d want %0d", n_valid - nv, 1);
    end
    vectors++;
    if (last_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL match_data: got %h want a5", last_data);
    end
    vectors++;
    if (last_match !== 1'b1) begin
      miscompares++;
      $display("FAIL match_flag: got %b want 1", last_match);
    end
    vectors++;
    if (n_err !== ne) begin
      miscompares++;
      $display("FAIL match_err: got %0d want 0", n_err - ne);
    end
    vectors++;
    if ((lat >= 604 && lat <= 612) !== 1'b1) begin
      miscompares++;
      $display("FAIL match_latency: got %0d want 604..612", lat);
    end
  endtask

  task automatic test_nomatch;
    int nv;
    nv = n_valid;
    own_addr = 8'hA5;
    send_frame(8'h3C, 1'b1);
    wait_clk(20);
    vectors++;
    if (n_valid !== nv + 1) begin
      miscompares++;
      $display("FAIL nomatch_count: got %0d want 1", n_valid - nv);
    end
    vectors++;
    if (last_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL nomatch_data: got %h want 3c", last_data);
    end
    vectors++;
    if (last_match !== 1'b0) begin
      miscompares++;
      $display("FAIL nomatch_flag: got %b want 0", last_match);
    end
  endtask

  task automatic test_frame_err;
    int nv, ne;
    nv = n_valid;
    ne = n_err;
    send_frame(8'h55, 1'b0);
    wait_clk(100);
    vectors++;
    if (n_err !== ne + 1) begin
      miscompares++;
      $display("FAIL ferr_count: got %0d want 1", n_err - ne);
    end
    vectors++;
    if (n_valid !== nv) begin
      miscompares++;
      $display("FAIL ferr_valid: got %0d want 0", n_valid - nv);
    end
    vectors++;
    if (rx_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL ferr_hold: got %h want 3c", rx_data);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_glitch;
    int nv, ne;
    nv = n_valid;
    ne = n_err;
    wait_clk(10);
    saw_busy = 1'b0;
    rxd = 1'b0;
    wait_clk(20);
    rxd = 1'b1;
    wait_clk(100);
    vectors++;
    if (saw_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy_rise: got %b want 1", saw_busy);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_fall: got %b want 0", busy);
    end
    vectors++;
    if ({n_valid - nv, n_err - ne} !== {32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL glitch_pulses: got valid %0d err %0d want 0 0", n_valid - nv, n_err - ne);
    end
    send_frame(8'h81, 1'b1);
    wait_clk(20);
    vectors++;
    if (n_valid !== nv + 1 || last_data !== 8'h81) begin
      miscompares++;
      $display("FAIL glitch_next: got %0d frames data %h want 1 frame 81", n_valid - nv,
               last_data);
    end
  endtask

  task automatic test_rst_midframe;
    int nv, ne;
    logic [7:0] d;
    d = 8'hF0;
    nv = n_valid;
    ne = n_err;
    rxd = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 3; i++) begin
      rxd = d[i];
      wait_clk(64);
    end
    rxd = d[3];
    wait_clk(32);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    rxd = 1'b1;
    vectors++;
    if ({rx_data, rx_valid, addr_match, frame_err, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL rst_mid_state: got data %h v%b m%b e%b b%b want all 0", rx_data,
               rx_valid, addr_match, frame_err, busy);
    end
    wait_clk(700);
    vectors++;
    if (n_valid !== nv || n_err !== ne) begin
      miscompares++;
      $display("FAIL rst_mid_pulse: got valid %0d err %0d want 0 0", n_valid - nv, n_err - ne);
    end
    send_frame(8'h0F, 1'b1);
    wait_clk(20);
    vectors++;
    if (rx_data !== 8'h0F || n_valid !== nv + 1) begin
      miscompares++;
      $display("FAIL rst_mid_next: got %h (%0d frames) want 0f (1 frame)", rx_data,
               n_valid - nv);
    end
  endtask

  task automatic test_back_to_back;
    int ne;
    logic [7:0] exp_d[3];
    logic       exp_m[3];
    exp_d = '{8'h00, 8'hFF, 8'h5A};
    exp_m = '{1'b0, 1'b1, 1'b0};
    ne = n_err;
    own_addr = 8'hFF;
    data_q.delete();
    match_q.delete();
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1);
    wait_clk(20);
    vectors++;
    if (data_q.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 3", data_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < data_q.size()) begin
        vectors++;
        if (data_q[i] !== exp_d[i] || match_q[i] !== exp_m[i]) begin
          miscompares++;
          $display("FAIL b2b_frame%0d: got %h/%b want %h/%b", i, data_q[i], match_q[i],
                   exp_d[i], exp_m[i]);
        end
      end
    end
    vectors++;
    if (n_err !== ne) begin
      miscompares++;
      $display("FAIL b2b_err: got %0d want 0", n_err - ne);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_nomatch();
    test_frame_err();
    test_glitch();
    test_rst_midframe();
    test_back_to_back();
    vectors++;
    if (n_long !== 0) begin
      miscompares++;
      $display("FAIL pulse_width: got %0d wide pulses want 0", n_long);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
